ddc112_readout_ctrl: RTL
========================

// Module: ddc112_readout_ctrl
// PURPOSE
//  Sequencer for one DDC112 dual-channel current-to-digital converter (or its bench model).
//  Generates the CONV integration toggle, waits for DVALID_BAR, drives DXMIT_BAR/DCLK to serially
//  read the 40-bit frame and presents CH2/CH1 20-bit words to downstream logic with valid/ack handshake.
//  Sits between the DDC112 pins and the acquisition FIFO/readout logic; all logic on SYS_CLK.
// PARAMETERS
//  CONV_PERIOD  10000  SYS_CLK cycles between CONV toggles (one integration half-cycle); >= 16
//  DCLK_DIV     4      SYS_CLK cycles per DCLK half-period; >= 2
//  DV_TIMEOUT   8000   max SYS_CLK cycles from CONV toggle to DVALID_BAR low before abort
//  NBITS        20     bits per channel; frame = 2*NBITS, CH2 first, MSB first
// PORTS
//  SYS_CLK     in   1      system clock
//  RST         in   1      asynchronous, active-high reset
//  EN          in   1      run enable (level)
//  DVALID_BAR  in   1      converter data-ready, active low, asynchronous to SYS_CLK
//  DOUT        in   1      converter serial data
//  CONV        out  1      integrator select toggle
//  DCLK        out  1      serial shift clock (idle low)
//  DXMIT_BAR   out  1      transmit enable, active low (idle high)
//  CH1_DATA    out  NBITS  last frame, channel 1 (frame bits [NBITS-1:0])
//  CH2_DATA    out  NBITS  last frame, channel 2 (frame bits [2*NBITS-1:NBITS])
//  DATA_VALID  out  1      CH1/CH2_DATA hold a new frame; held until DATA_ACK
//  DATA_ACK    in   1      consumer accepts frame; clears DATA_VALID next cycle
//  OVERRUN     out  1      1-cycle pulse: frame completed while DATA_VALID still high (new frame dropped)
//  TIMEOUT     out  1      1-cycle pulse: DVALID_BAR not seen within DV_TIMEOUT
//  OVERLAP     out  1      1-cycle pulse: CONV toggle fell while in XMIT/SHIFT
// BEHAVIOUR
//  Reset: CONV=0, DCLK=0, DXMIT_BAR=1, CH1/CH2_DATA=0, DATA_VALID=0, all pulses 0, state IDLE, counters 0.
//  DVALID_BAR passes a 2-FF synchroniser; "dv" = synchronised level low. DOUT sampled directly (stable while DCLK low).
//  Conv timer: while EN=1, counts 0..CONV_PERIOD-1; at terminal count CONV toggles and conv_tick pulses 1 cycle.
//   EN=0 freezes counter at 0, CONV holds its level. Toggles always on schedule, never deferred.
//  FSM states / transitions:
//   IDLE   : conv_tick & EN -> WAIT (timeout counter cleared).
//   WAIT   : dv -> SETUP; else counter==DV_TIMEOUT-1 -> TIMEOUT pulse, IDLE.
//   SETUP  : DXMIT_BAR=0 for DCLK_DIV cycles (first bit settles) -> SHIFT.
//   SHIFT  : per bit: DCLK low DCLK_DIV cycles, then high DCLK_DIV cycles. DOUT is shifted into a
//            2*NBITS register on the SYS_CLK edge that drives DCLK 0->1. After 2*NBITS rising edges and
//            the final high phase DCLK returns low -> DONE.
//   DONE   : DXMIT_BAR=1; if DATA_VALID=0 (or DATA_ACK=1 this cycle) load CH2/CH1 and set DATA_VALID,
//            else OVERRUN pulse, outputs unchanged. -> IDLE.
//  conv_tick in SETUP/SHIFT -> OVERLAP pulse, readout continues. conv_tick in WAIT -> restart timeout count.
//  conv_tick in DONE is treated as arriving in IDLE on the next cycle (not lost).
//  EN falling mid-frame: current readout completes; FSM returns to IDLE and stays (no new ticks).
//  DATA_ACK with DATA_VALID=0: ignored. DATA_ACK and new load same cycle: load wins, DATA_VALID stays 1.
//  Readout latency from dv detect to DATA_VALID: DCLK_DIV + 2*NBITS*2*DCLK_DIV + 1 cycles (325 at defaults).
//  RST asserted mid-operation: immediate return to reset values, including DXMIT_BAR=1, DCLK=0.
// STRUCTURE
//  Package ddc112_pkg: state enum (IDLE/WAIT/SETUP/SHIFT/DONE), DDC_NBITS=20, DDC_FRAME=40 constants.
//  Sub-module ddc112_conv_timer: CONV_PERIOD counter, CONV toggle register, conv_tick output.
//  Synchroniser, shift register, DCLK phase counter and FSM live in this module.
// TESTING (bench drives the DDC112 behavioural model with mock_time 4500, data incrementing per frame)
//  Reset then EN=1 -> first CONV toggle at cycle 10000; DVALID_BAR low ~4500 later; DATA_VALID with
//   CH1=CH2=1, then 2,3,... on successive frames with DATA_ACK pulsed after each.
//  Check pins: DXMIT_BAR low exactly one window per frame, exactly 40 DCLK rising edges, DCLK 8-cycle period.
//  DATA_ACK withheld across two frames -> second frame raises OVERRUN 1 cycle, CH data stays at 1.
//  Model DVALID_BAR tied high -> TIMEOUT pulse 8000 cycles after toggle, DXMIT_BAR never low, no DATA_VALID.
//  CONV_PERIOD=4700 -> toggle lands in SHIFT -> OVERLAP pulse, frame still read correctly.
//  RST pulsed during SHIFT -> DXMIT_BAR=1, DCLK=0, DATA_VALID=0 next edge; clean frame after release.

Source files
------------

// File: rtl/ddc112_pkg.sv
// Shared types and constants for the DDC112 readout slice.
// FSM state encoding plus default channel and frame widths.
package ddc112_pkg;

    localparam int DDC_NBITS = 20;
    localparam int DDC_FRAME = 2 * DDC_NBITS;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SETUP,
        SHIFT,
        DONE
    } ddc_state_t;

endpackage

// File: rtl/ddc112_readout_ctrl_if.sv
// Frame hand-off from the DDC112 sequencer to the consumer.
// Ports: CH1_DATA, CH2_DATA, DATA_VALID (master out), DATA_ACK (master in).
interface ddc112_readout_ctrl_if
    import ddc112_pkg::*;
#(
    parameter int NBITS = DDC_NBITS
);

    logic [NBITS-1:0] CH1_DATA;
    logic [NBITS-1:0] CH2_DATA;
    logic             DATA_VALID;
    logic             DATA_ACK;

    modport master (
        output CH1_DATA,
        output CH2_DATA,
        output DATA_VALID,
        input  DATA_ACK
    );

    modport slave (
        input  CH1_DATA,
        input  CH2_DATA,
        input  DATA_VALID,
        output DATA_ACK
    );

endinterface

// File: rtl/ddc112_conv_timer.sv
// Integration timer: toggles CONV every CONV_PERIOD cycles while EN.
// Ports: SYS_CLK, RST (async high), EN in; CONV level and 1-cycle conv_tick out.
module ddc112_conv_timer
    import ddc112_pkg::*;
#(
    parameter int CONV_PERIOD = 10000
) (
    input  logic SYS_CLK,
    input  logic RST,
    input  logic EN,
    output logic CONV,
    output logic conv_tick
);

    localparam int CW = $clog2(CONV_PERIOD);

    logic [CW-1:0] cnt;

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            cnt       <= '0;
            CONV      <= 1'b0;
            conv_tick <= 1'b0;
        end else begin
            conv_tick <= 1'b0;
            if (!EN) begin
                cnt <= '0;
            end else if (cnt == CW'(CONV_PERIOD - 1)) begin
                cnt       <= '0;
                CONV      <= ~CONV;
                conv_tick <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ddc112_readout_ctrl.sv
// DDC112 sequencer: CONV timing, DVALID wait, serial frame readout, frame hand-off.
// Ports: SYS_CLK, RST, EN, DVALID_BAR, DOUT in; CONV, DCLK, DXMIT_BAR,
//        OVERRUN, TIMEOUT, OVERLAP out; data_if (master) carries CH1/CH2 with valid/ack.
module ddc112_readout_ctrl
    import ddc112_pkg::*;
#(
    parameter int CONV_PERIOD = 10000,
    parameter int DCLK_DIV    = 4,
    parameter int DV_TIMEOUT  = 8000,
    parameter int NBITS       = DDC_NBITS
) (
    input  logic SYS_CLK,
    input  logic RST,
    input  logic EN,
    input  logic DVALID_BAR,
    input  logic DOUT,
    output logic CONV,
    output logic DCLK,
    output logic DXMIT_BAR,
    output logic OVERRUN,
    output logic TIMEOUT,
    output logic OVERLAP,
    ddc112_readout_ctrl_if.master data_if
);

    localparam int FRAME = 2 * NBITS;
    localparam int TW    = $clog2(DV_TIMEOUT);
    localparam int PW    = $clog2(DCLK_DIV);
    localparam int BW    = $clog2(FRAME);

    ddc_state_t       state;
    logic             conv_tick;
    logic             tick_pend;
    logic             dvb_s1;
    logic             dvb_s2;
    logic             dv;
    logic [TW-1:0]    tcnt;
    logic [PW-1:0]    pcnt;
    logic [BW-1:0]    bcnt;
    logic [FRAME-1:0] sreg;
    logic [NBITS-1:0] ch1_q;
    logic [NBITS-1:0] ch2_q;
    logic             valid_q;

    ddc112_conv_timer #(
        .CONV_PERIOD(CONV_PERIOD)
    ) u_timer (
        .SYS_CLK  (SYS_CLK),
        .RST      (RST),
        .EN       (EN),
        .CONV     (CONV),
        .conv_tick(conv_tick)
    );

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            dvb_s1 <= 1'b1;
            dvb_s2 <= 1'b1;
        end else begin
            dvb_s1 <= DVALID_BAR;
            dvb_s2 <= dvb_s1;
        end
    end

    assign dv = ~dvb_s2;

    assign data_if.CH1_DATA   = ch1_q;
    assign data_if.CH2_DATA   = ch2_q;
    assign data_if.DATA_VALID = valid_q;

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            tick_pend <= 1'b0;
            tcnt      <= '0;
            pcnt      <= '0;
            bcnt      <= '0;
            sreg      <= '0;
            DCLK      <= 1'b0;
            DXMIT_BAR <= 1'b1;
            ch1_q     <= '0;
            ch2_q     <= '0;
            valid_q   <= 1'b0;
            OVERRUN   <= 1'b0;
            TIMEOUT   <= 1'b0;
            OVERLAP   <= 1'b0;
        end else begin
            OVERRUN <= 1'b0;
            TIMEOUT <= 1'b0;
            OVERLAP <= 1'b0;
            // ack clears first so a same-cycle load in DONE wins
            if (data_if.DATA_ACK) begin
                valid_q <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    tick_pend <= 1'b0;
                    if ((conv_tick || tick_pend) && EN) begin
                        state <= WAIT;
                        tcnt  <= '0;
                    end
                end
                WAIT: begin
                    if (dv) begin
                        state     <= SETUP;
                        DXMIT_BAR <= 1'b0;
                        pcnt      <= '0;
                    end else if (conv_tick) begin
                        tcnt <= '0;
                    end else if (tcnt == TW'(DV_TIMEOUT - 1)) begin
                        TIMEOUT <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                SETUP: begin
                    if (conv_tick) begin
                        OVERLAP <= 1'b1;
                    end
                    if (pcnt == PW'(DCLK_DIV - 1)) begin
                        pcnt  <= '0;
                        bcnt  <= '0;
                        state <= SHIFT;
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                SHIFT: begin
                    if (conv_tick) begin
                        OVERLAP <= 1'b1;
                    end
                    if (pcnt != PW'(DCLK_DIV - 1)) begin
                        pcnt <= pcnt + PW'(1);
                    end else begin
                        pcnt <= '0;
                        DCLK <= ~DCLK;
                        // DOUT is stable through the low phase; take it as DCLK rises
                        if (!DCLK) begin
                            sreg <= {sreg[FRAME-2:0], DOUT};
                        end else if (bcnt == BW'(FRAME - 1)) begin
                            state     <= DONE;
                            DXMIT_BAR <= 1'b1;
                        end else begin
                            bcnt <= bcnt + BW'(1);
                        end
                    end
                end
                DONE: begin
                    // a tick here is replayed by IDLE on the next cycle
                    tick_pend <= conv_tick;
                    state     <= IDLE;
                    if (!valid_q || data_if.DATA_ACK) begin
                        ch2_q   <= sreg[FRAME-1:NBITS];
                        ch1_q   <= sreg[NBITS-1:0];
                        valid_q <= 1'b1;
                    end else begin
                        OVERRUN <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
